pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Hazard and exception controller for the 5-stage Y86-64 pipeline. Every cycle it drives the stall/bubble
//  controls of the F, D, E, M and W pipeline registers, including the M->W writeback register.
//  It resolves load/use hazards, jXX mispredictions and ret, and halts the pipeline on HLT/ADR/INS.
//  It also keeps saturating performance counters. Placed beside the stage registers in the top level.
// PARAMETERS
//  CNT_W   32   width of each performance counter
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      asynchronous reset, active-high
//  D_icode         in   4      icode held in D register
//  d_srcA,d_srcB   in   4      decode-stage source regs (4'hF = RNONE)
//  E_icode,E_dstM  in   4      icode / memory destination held in E register
//  e_Cnd           in   1      execute-stage condition result
//  M_icode         in   4      icode held in M register
//  m_status        in   3      memory-stage status after data-memory access
//  W_status        in   3      status held in W register
//  F_stall,D_stall out  1      hold F / D register
//  D_bubble,E_bubble,M_bubble out 1   load NOP into D / E / M register
//  W_stall         out  1      hold W register
//  halted          out  1      pipeline stopped (sticky)
//  final_status    out  3      status that caused the halt; AOK while running
//  cycle_cnt,loaduse_cnt,mispred_cnt,ret_cnt out CNT_W  performance counters
// BEHAVIOUR
//  Reset (async, rst=1): state=RUN, halted=0, final_status=AOK, all counters 0.
//  While rst is high: F_stall=D_stall=W_stall=1 and all bubbles=0.
//  Controls are combinational from the inputs and the current state (0-cycle latency).
//  Counters and state update on posedge clk.
//  Derived terms:
//   loaduse = E_icode in {MRMOVQ,POPQ} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB)
//   mispred = E_icode==JXX && !e_Cnd
//   retpend = RET in {D_icode,E_icode,M_icode}
//   m_exc = m_status in {ADR,INS,HLT};  w_exc = W_status in {ADR,INS,HLT}
//  State RUN:
//   F_stall = loaduse | retpend;  D_stall = loaduse
//   D_bubble = mispred | (retpend & ~loaduse);  E_bubble = mispred | loaduse
//   M_bubble = m_exc | w_exc;  W_stall = w_exc
//   Priority: loaduse suppresses D_bubble. D_stall and D_bubble are never both 1.
//   mispred and loaduse cannot co-occur, because the E-stage icode differs.
//  Transitions:
//   RUN -> DRAIN when m_exc & ~w_exc
//   RUN or DRAIN -> HALT when w_exc; on that edge final_status <= W_status and halted <= 1
//   DRAIN -> RUN never.
//   DRAIN uses the RUN equations but forces M_bubble=1, so no younger instruction reaches W.
//  State HALT (sticky until rst):
//   F_stall=D_stall=W_stall=1;  E_bubble=M_bubble=1;  D_bubble=0
//  Counters (RUN and DRAIN only; frozen in HALT; saturate at all-ones, no wrap):
//   cycle_cnt +1 every cycle; loaduse_cnt +1 when loaduse; mispred_cnt +1 when mispred
//   ret_cnt +1 when retpend & ~loaduse
//  Reset asserted mid-operation aborts any state immediately.
//  Inputs that are X during HALT must not affect the outputs.
// STRUCTURE
//  Shared package y86_pkg:
//   icode constants (HALT=0 NOP=1 CMOVXX=2 IRMOVQ=3 RMMOVQ=4 MRMOVQ=5 OPQ=6 JXX=7 CALL=8 RET=9
//   PUSHQ=A POPQ=B), RNONE=4'hF
//   status codes AOK=1 HLT=2 ADR=3 INS=4
//   state enum RUN/DRAIN/HALT
//  One sub-module: sat_counter #(CNT_W) (clk, rst, inc, q), instantiated four times.
//  The hazard equations stay flat in pipe_ctrl.
// TESTING
//  1 Reset: rst=1 -> halted=0, final_status=1, counters 0, F_stall=D_stall=W_stall=1.
//    Release rst -> cycle_cnt counts 1,2,3...
//  2 Load/use: E_icode=5, E_dstM=3, d_srcB=3 for 1 cycle
//    -> F_stall=D_stall=E_bubble=1, D_bubble=0; loaduse_cnt=1.
//    Same case with E_dstM=F -> all controls 0.
//  3 Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mispred_cnt=1.
//    Same with e_Cnd=1 -> no bubbles.
//  4 Ret: D_icode=9, then E_icode=9, then M_icode=9 over 3 cycles
//    -> F_stall=D_bubble=1 on each of the 3 cycles; ret_cnt=3.
//    Ret with a simultaneous load/use -> D_stall=1, D_bubble=0.
//  5 Exception: m_status=3 for 1 cycle -> M_bubble=1 and state DRAIN.
//    Next cycle W_status=3 -> W_stall=1; after the edge halted=1, final_status=3.
//    All controls then stay in HALT values and counters freeze, even when inputs return to AOK.
//  6 Saturation: CNT_W=4, run 20 cycles -> cycle_cnt holds at 15.
//    Assert rst mid-HALT -> state RUN and counters 0 asynchronously, without a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the pipeline controller.
// Holds the instruction codes, register/status encodings, the controller
// state enum and a helper that classifies a status as exceptional.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // "No register" marker
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // Controller state
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  // A status that must stop the pipeline
  function automatic logic is_exc(input logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stage registers and the hazard controller.
// master: pipeline side, drives stage contents/status and receives controls.
// slave : controller side, observes stage contents/status and drives controls.
//   D_icode, d_srcA, d_srcB   decode-stage icode and source registers
//   E_icode, E_dstM, e_Cnd    execute-stage icode, load destination, condition
//   M_icode, m_status         memory-stage icode and post-access status
//   W_status                  status held in the W register
//   F_stall, D_stall, W_stall hold the F / D / W register
//   D_bubble, E_bubble, M_bubble  load a NOP into D / E / M
interface pipe_ctrl_if;

  logic [3:0] D_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [3:0] M_icode;
  logic [2:0] m_status;
  logic [2:0] W_status;

  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_status, W_status,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_status, W_status,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high clear
//   inc  in   count enable for this cycle
//   q    out  count value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and exception controller for the 5-stage Y86-64 pipeline.
// Drives the stall/bubble controls of the F, D, E, M and W registers every
// cycle (combinational, zero latency), resolves load/use, jXX mispredict and
// ret hazards, stops the pipeline on HLT/ADR/INS and keeps saturating
// performance counters.
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   pif           slave side of pipe_ctrl_if (stage contents in, controls out)
//   halted        sticky "pipeline stopped"
//   final_status  status that caused the halt; AOK while running
//   cycle_cnt     cycles spent in RUN/DRAIN
//   loaduse_cnt   load/use stalls
//   mispred_cnt   mispredicted jumps
//   ret_cnt       cycles bubbling D for a pending ret
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       pif,
  output logic             halted,
  output logic [2:0]       final_status,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  ctrl_state_e state, next_state;

  logic loaduse;
  logic mispred;
  logic retpend;
  logic m_exc;
  logic w_exc;
  logic active;

  // Hazard terms, evaluated flat from the stage contents
  always_comb begin
    loaduse = ((pif.E_icode == I_MRMOVQ) || (pif.E_icode == I_POPQ)) &&
              (pif.E_dstM != RNONE) &&
              ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    mispred = (pif.E_icode == I_JXX) && !pif.e_Cnd;
    retpend = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) ||
              (pif.M_icode == I_RET);
    m_exc   = is_exc(pif.m_status);
    w_exc   = is_exc(pif.W_status);
  end

  // State register; halted/final_status are captured on the edge into HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      halted       <= 1'b0;
      final_status <= S_AOK;
    end else begin
      state <= next_state;
      if ((state != ST_HALT) && (next_state == ST_HALT)) begin
        halted       <= 1'b1;
        final_status <= pif.W_status;
      end
    end
  end

  // Next state: an exception reaching W always wins over one still in M
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (w_exc) begin
          next_state = ST_HALT;
        end else if (m_exc) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_exc) begin
          next_state = ST_HALT;
        end
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_HALT;
    endcase
  end

  // Controls. The HALT branch reads no pipeline inputs, so unknown values on
  // them cannot leak into the controls once the pipeline has stopped.
  always_comb begin
    pif.F_stall  = 1'b0;
    pif.D_stall  = 1'b0;
    pif.D_bubble = 1'b0;
    pif.E_bubble = 1'b0;
    pif.M_bubble = 1'b0;
    pif.W_stall  = 1'b0;
    if (rst) begin
      pif.F_stall = 1'b1;
      pif.D_stall = 1'b1;
      pif.W_stall = 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_DRAIN: begin
          pif.F_stall  = loaduse | retpend;
          pif.D_stall  = loaduse;
          // a load/use stall holds D, so it must not also be bubbled
          pif.D_bubble = mispred | (retpend & ~loaduse);
          pif.E_bubble = mispred | loaduse;
          // while draining, nothing younger than the faulting op may reach W
          pif.M_bubble = m_exc | w_exc | (state == ST_DRAIN);
          pif.W_stall  = w_exc;
        end
        default: begin
          pif.F_stall  = 1'b1;
          pif.D_stall  = 1'b1;
          pif.E_bubble = 1'b1;
          pif.M_bubble = 1'b1;
          pif.W_stall  = 1'b1;
        end
      endcase
    end
  end

  // Counters only advance while the pipeline is live
  assign active = (state == ST_RUN) || (state == ST_DRAIN);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active),
    .q   (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active && loaduse),
    .q   (loaduse_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active && mispred),
    .q   (mispred_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active && retpend && !loaduse),
    .q   (ret_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a 32-bit-counter instance and a 4-bit
// instance share the same stimulus; both are checked against a behavioural
// model of the controller kept here.
module tb_pipe_ctrl;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl_if bus4 ();

  assign bus4.D_icode  = bus.D_icode;
  assign bus4.d_srcA   = bus.d_srcA;
  assign bus4.d_srcB   = bus.d_srcB;
  assign bus4.E_icode  = bus.E_icode;
  assign bus4.E_dstM   = bus.E_dstM;
  assign bus4.e_Cnd    = bus.e_Cnd;
  assign bus4.M_icode  = bus.M_icode;
  assign bus4.m_status = bus.m_status;
  assign bus4.W_status = bus.W_status;

  logic        halted, halted4;
  logic [2:0]  final_status, final_status4;
  logic [31:0] cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt;
  logic [3:0]  cycle4, loaduse4, mispred4, ret4;

  pipe_ctrl #(.CNT_W(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .pif          (bus.slave),
    .halted       (halted),
    .final_status (final_status),
    .cycle_cnt    (cycle_cnt),
    .loaduse_cnt  (loaduse_cnt),
    .mispred_cnt  (mispred_cnt),
    .ret_cnt      (ret_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .pif          (bus4.slave),
    .halted       (halted4),
    .final_status (final_status4),
    .cycle_cnt    (cycle4),
    .loaduse_cnt  (loaduse4),
    .mispred_cnt  (mispred4),
    .ret_cnt      (ret4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = running, 1 = draining, 2 = stopped
  int         mode;
  logic [2:0] m_final;
  longint     n_cyc, n_lu, n_mp, n_ret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic longint clip(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic ld_use();
    return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
           (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  endfunction

  function automatic logic misp();
    return bus.E_icode == 4'h7 && bus.e_Cnd == 1'b0;
  endfunction

  function automatic logic retp();
    return bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
  endfunction

  function automatic logic bad_st(input logic [2:0] s);
    return s == 3'd2 || s == 3'd3 || s == 3'd4;
  endfunction

  // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  function automatic logic [5:0] model_ctrl();
    logic lu, mp, rp, me, we;
    if (rst) return 6'b110001;
    if (mode == 2) return 6'b110111;
    lu = ld_use(); mp = misp(); rp = retp();
    me = bad_st(bus.m_status); we = bad_st(bus.W_status);
    return {lu | rp, lu, mp | (rp & ~lu), mp | lu, me | we | (mode == 1), we};
  endfunction

  task automatic model_reset();
    mode = 0; m_final = 3'd1;
    n_cyc = 0; n_lu = 0; n_mp = 0; n_ret = 0;
  endtask

  task automatic set_idle();
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_Cnd = 1'b1;
    bus.M_icode = 4'h1; bus.m_status = 3'd1; bus.W_status = 3'd1;
  endtask

  task automatic check_ctrl(input string tag);
    logic [5:0] exp;
    exp = model_ctrl();
    check({tag, ".ctrl"}, {bus.F_stall, bus.D_stall, bus.D_bubble,
                            bus.E_bubble, bus.M_bubble, bus.W_stall}, exp);
    check({tag, ".ctrl4"}, {bus4.F_stall, bus4.D_stall, bus4.D_bubble,
                             bus4.E_bubble, bus4.M_bubble, bus4.W_stall}, exp);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".halted"}, halted, mode == 2);
    check({tag, ".final"},  final_status, m_final);
    check({tag, ".cyc"},    cycle_cnt,   clip(n_cyc, 64'hFFFF_FFFF));
    check({tag, ".lu"},     loaduse_cnt, clip(n_lu,  64'hFFFF_FFFF));
    check({tag, ".mp"},     mispred_cnt, clip(n_mp,  64'hFFFF_FFFF));
    check({tag, ".ret"},    ret_cnt,     clip(n_ret, 64'hFFFF_FFFF));
    check({tag, ".halted4"}, halted4, mode == 2);
    check({tag, ".final4"},  final_status4, m_final);
    check({tag, ".cyc4"},    cycle4,   clip(n_cyc, 15));
    check({tag, ".lu4"},     loaduse4, clip(n_lu,  15));
    check({tag, ".mp4"},     mispred4, clip(n_mp,  15));
    check({tag, ".ret4"},    ret4,     clip(n_ret, 15));
  endtask

  // Advance the model with the pre-edge inputs, then cross one clock edge
  task automatic tick();
    if (mode != 2) begin
      n_cyc++;
      if (ld_use()) n_lu++;
      if (misp()) n_mp++;
      if (retp() && !ld_use()) n_ret++;
      if (bad_st(bus.W_status)) begin
        mode = 2; m_final = bus.W_status;
      end else if (mode == 0 && bad_st(bus.m_status)) begin
        mode = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    #1;
    check_ctrl(tag);
    tick();
    check_regs(tag);
  endtask

  // Assert reset between edges and check it took effect without a clock
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_ctrl(tag);
    check_regs(tag);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [2:0] rnd_status(input int odds);
    if ($urandom_range(0, odds) == 0) return 3'($urandom_range(2, 4));
    return 3'd1;
  endfunction

  initial begin
    int halt_cycles;
    rst = 1'b1;
    set_idle();
    model_reset();
    #12;
    check_ctrl("reset");
    check_regs("reset");
    rst = 1'b0;
    repeat (3) step("run");

    // Load/use, then the same with RNONE destination
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcB = 4'h3;
    step("loaduse");
    bus.E_dstM = 4'hF;
    step("loaduse_rnone");
    set_idle();

    // Mispredict taken / not taken
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;
    step("mispred");
    bus.e_Cnd = 1'b1;
    step("jxx_taken");
    set_idle();

    // ret walking D -> E -> M
    bus.D_icode = 4'h9; step("ret_d"); set_idle();
    bus.E_icode = 4'h9; step("ret_e"); set_idle();
    bus.M_icode = 4'h9; step("ret_m"); set_idle();
    check("ret_cnt3", ret_cnt, 3);
    // ret with a simultaneous load/use
    bus.M_icode = 4'h9; bus.E_icode = 4'h5; bus.E_dstM = 4'h2; bus.d_srcA = 4'h2;
    step("ret_lu");
    set_idle();

    // Exception in M, then in W, then stay halted
    bus.m_status = 3'd3;
    step("exc_m");
    set_idle();
    bus.W_status = 3'd3;
    step("exc_w");
    check("final_adr", final_status, 3);
    set_idle();
    repeat (3) step("halt_idle");
    bus.D_icode = 4'h9; bus.E_icode = 4'h5; bus.E_dstM = 4'h1; bus.d_srcA = 4'h1;
    bus.m_status = 3'bx; bus.W_status = 3'bx; bus.e_Cnd = 1'bx;
    step("halt_x");
    set_idle();

    // Reset mid-halt, then saturate the 4-bit counter
    async_reset("rst_halt");
    repeat (20) step("sat");
    check("sat15", cycle4, 15);

    // Randomised run with occasional exceptions and reset recovery
    halt_cycles = 0;
    for (int i = 0; i < 800; i++) begin
      bus.D_icode  = 4'($urandom_range(0, 11));
      bus.E_icode  = 4'($urandom_range(0, 11));
      bus.M_icode  = 4'($urandom_range(0, 11));
      bus.E_dstM   = rnd_reg();
      bus.d_srcA   = rnd_reg();
      bus.d_srcB   = rnd_reg();
      bus.e_Cnd    = 1'($urandom_range(0, 1));
      bus.m_status = rnd_status(40);
      bus.W_status = rnd_status(60);
      step("rand");
      if (mode == 2) begin
        halt_cycles++;
        if (halt_cycles > 4) begin
          halt_cycles = 0;
          async_reset("rand_rst");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
